stall_mem_responder: RTL and testbench

//   Multi-cycle data-memory responder: the target side of the processor's

---
 rtl/stall_mem_responder.sv | 105 ++++++++++
 tb/tb_stall_mem_responder.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/stall_mem_responder.sv
// Fixed-latency data-memory responder for the core's MEMORY slot.
// A legal request is accepted in IDLE, commits LATENCY-1 edges later, and is acknowledged by a one-cycle done pulse.
module stall_mem_responder #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 8,
  parameter int LATENCY    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  input  logic              read_en,
  input  logic              write_en,
  output logic [DATA_W-1:0] read_data,
  output logic              done,
  output logic              stall,
  output logic              err
);

  // Handshake: the core raises read_en or write_en and must hold its request
  // and PC while stall=1. The responder ends the access with done=1 for one
  // cycle, and stall=0 in that cycle. Requests present in the done cycle are
  // not accepted. A held request is accepted in the next IDLE cycle.
  // err=1 flags a request that is refused; it never coincides with stall.

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  state_t                state;
  logic [3:0]            cnt;
  logic [DEPTH_LOG2-1:0] lat_idx;
  logic [DATA_W-1:0]     lat_data;
  logic                  lat_we;

  logic [DATA_W-1:0] mem [0:(1<<DEPTH_LOG2)-1];

  logic                  req;
  logic                  illegal;
  logic                  accept;
  logic                  commit_now;
  logic                  commit_we;
  logic [DEPTH_LOG2-1:0] commit_idx;
  logic [DATA_W-1:0]     commit_data;

  assign req     = read_en | write_en;
  assign illegal = (read_en & write_en) | addr[0] |
                   (addr[ADDR_W-1:DEPTH_LOG2+1] != '0);
  assign accept  = (state == IDLE) & req & ~illegal;

  // A single-cycle access commits on its acceptance edge, straight from the inputs.
  assign commit_now  = ((LATENCY == 1) & accept) | ((state == WAIT) & (cnt == 4'd0));
  assign commit_we   = (state == IDLE) ? write_en               : lat_we;
  assign commit_idx  = (state == IDLE) ? addr[DEPTH_LOG2:1]     : lat_idx;
  assign commit_data = (state == IDLE) ? write_data             : lat_data;

  assign stall = ~rst & (accept | (state == WAIT));
  assign err   = ~rst & (state == IDLE) & req & illegal;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      done      <= 1'b0;
      read_data <= '0;
      lat_idx   <= '0;
      lat_data  <= '0;
      lat_we    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (commit_now) begin
        done <= 1'b1;
        if (!commit_we) read_data <= mem[commit_idx];
      end
      case (state)
        IDLE: begin
          if (accept) begin
            lat_idx  <= addr[DEPTH_LOG2:1];
            lat_data <= write_data;
            lat_we   <= write_en;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_INIT;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The array is deliberately left out of reset so its contents survive an abort.
  always_ff @(posedge clk) begin
    if (commit_now && commit_we) mem[commit_idx] <= commit_data;
  end

endmodule

// File: tb/tb_stall_mem_responder.sv
// Directed and randomized bench for stall_mem_responder (LATENCY=4 and LATENCY=1 instances).
module tb_stall_mem_responder;

  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] addr, write_data, read_data;
  logic        read_en, write_en, done, stall, err;

  logic [15:0] r1_addr, r1_write_data, r1_read_data;
  logic        r1_read_en, r1_write_en, r1_done, r1_stall, r1_err;

  stall_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(L)) u_dut (
    .clk(clk), .rst(rst), .addr(addr), .write_data(write_data),
    .read_en(read_en), .write_en(write_en), .read_data(read_data),
    .done(done), .stall(stall), .err(err)
  );

  stall_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(8), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .addr(r1_addr), .write_data(r1_write_data),
    .read_en(r1_read_en), .write_en(r1_write_en), .read_data(r1_read_data),
    .done(r1_done), .stall(r1_stall), .err(r1_err)
  );

  int          checks = 0;
  int          errors = 0;
  logic [15:0] model_mem  [256];
  logic [15:0] model_mem1 [256];
  logic [15:0] exp_rd;
  logic [15:0] exp_rd1;
  logic [15:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete legal access on the LATENCY=4 port; entered and left at posedge+1.
  task automatic access(input bit we, input logic [15:0] a, input logic [15:0] d, input bit hold);
    logic [15:0] want;
    read_en = ~we; write_en = we; addr = a; write_data = d;
    if (!we) exp_q.push_back(model_mem[a[8:1]]);
    for (int c = 0; c <= L; c++) begin
      #4;
      chk("stall", {31'd0, stall}, {31'd0, (c < L)});
      chk("done", {31'd0, done}, {31'd0, (c == L)});
      chk("err_legal", {31'd0, err}, 32'd0);
      if (c == L && !we) begin
        want = exp_q.pop_front();
        chk("rdata_load", {16'd0, read_data}, {16'd0, want});
        exp_rd = want;
      end else begin
        chk("rdata_hold", {16'd0, read_data}, {16'd0, exp_rd});
      end
      @(posedge clk); #1;
      if (c < L - 1) begin
        addr = 16'($urandom); write_data = 16'($urandom);
      end else if (c == L - 1) begin
        if (hold) begin addr = a; write_data = d; end
        else begin read_en = 1'b0; write_en = 1'b0; end
      end
    end
    if (we) model_mem[a[8:1]] = d;
  endtask

  task automatic illegal_req(input logic re, input logic we, input logic [15:0] a);
    read_en = re; write_en = we; addr = a; write_data = 16'($urandom);
    #4;
    chk("err_flag", {31'd0, err}, 32'd1);
    chk("err_nostall", {31'd0, stall}, 32'd0);
    chk("err_nodone", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    read_en = 1'b0; write_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #4;
      chk("after_err_done", {31'd0, done}, 32'd0);
      chk("after_err_stall", {31'd0, stall}, 32'd0);
      chk("after_err_rdata", {16'd0, read_data}, {16'd0, exp_rd});
      @(posedge clk); #1;
    end
  endtask

  task automatic access1(input bit we, input logic [15:0] a, input logic [15:0] d);
    r1_read_en = ~we; r1_write_en = we; r1_addr = a; r1_write_data = d;
    #4;
    chk("l1_stall_c0", {31'd0, r1_stall}, 32'd1);
    chk("l1_done_c0", {31'd0, r1_done}, 32'd0);
    @(posedge clk); #1;
    r1_read_en = 1'b0; r1_write_en = 1'b0;
    if (we) model_mem1[a[8:1]] = d;
    else    exp_rd1 = model_mem1[a[8:1]];
    #4;
    chk("l1_stall_c1", {31'd0, r1_stall}, 32'd0);
    chk("l1_done_c1", {31'd0, r1_done}, 32'd1);
    chk("l1_rdata", {16'd0, r1_read_data}, {16'd0, exp_rd1});
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0]  idx;
    logic [15:0] d;
    bit          we;

    rst = 1'b1;
    read_en = 1'b0; write_en = 1'b0; addr = '0; write_data = '0;
    r1_read_en = 1'b0; r1_write_en = 1'b0; r1_addr = '0; r1_write_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdata", {16'd0, read_data}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata1", {16'd0, r1_read_data}, 32'd0);
    rst = 1'b0;
    exp_rd = 16'h0000;
    exp_rd1 = 16'h0000;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) access(1'b1, 16'(i * 2), 16'($urandom), 1'b0);

    // Store then load at 0x0010.
    access(1'b1, 16'h0010, 16'h1234, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 1'b0);

    // Read and write together is refused; contents survive.
    access(1'b1, 16'h0020, 16'h00A5, 1'b0);
    illegal_req(1'b1, 1'b1, 16'h0020);
    access(1'b0, 16'h0020, 16'h0000, 1'b0);

    // Misaligned, out of range, and a refused misaligned store.
    illegal_req(1'b1, 1'b0, 16'h0011);
    illegal_req(1'b1, 1'b0, 16'h0200);
    illegal_req(1'b0, 1'b1, 16'h0013);
    access(1'b0, 16'h0012, 16'h0000, 1'b0);

    // A request held through done is accepted again right after the pulse.
    access(1'b0, 16'h0010, 16'h0000, 1'b1);
    access(1'b0, 16'h0010, 16'h0000, 1'b0);

    // Reset during a store aborts it; the old word stays.
    access(1'b1, 16'h0040, 16'h0001, 1'b0);
    access(1'b0, 16'h0010, 16'h0000, 1'b0);
    read_en = 1'b0; write_en = 1'b1; addr = 16'h0040; write_data = 16'hBEEF;
    #4;
    chk("abort_stall_c0", {31'd0, stall}, 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_rdata", {16'd0, read_data}, 32'd0);
    chk("abort_stall", {31'd0, stall}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_err", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    write_en = 1'b0; rst = 1'b0; exp_rd = 16'h0000;
    #4;
    chk("post_rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    access(1'b0, 16'h0040, 16'h0000, 1'b0);

    // Random traffic over a small window so read-after-write hits often.
    for (int n = 0; n < 40; n++) begin
      idx = 8'($urandom_range(0, 15));
      we  = 1'($urandom_range(0, 1));
      d   = 16'($urandom);
      if ($urandom_range(0, 5) == 0) illegal_req(1'b1, 1'b1, {7'd0, idx, 1'b0});
      access(we, {7'd0, idx, 1'b0}, d, 1'b0);
    end

    // Single-cycle latency instance.
    for (int i = 0; i < 4; i++) access1(1'b1, 16'(i * 2), 16'($urandom));
    access1(1'b1, 16'h0004, 16'h5A5A);
    access1(1'b0, 16'h0004, 16'h0000);
    for (int n = 0; n < 8; n++) begin
      idx = 8'($urandom_range(0, 3));
      access1(1'($urandom_range(0, 1)), {7'd0, idx, 1'b0}, 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
